// File: rtl/mips_dump_pkg.sv
// Shared definitions for the memory dump reader: FSM encoding, tag constant, width helper.
package mips_dump_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RF_RD   = 3'd1,
        DM_REQ  = 3'd2,
        DM_WAIT = 3'd3,
        EMIT    = 3'd4,
        FIN     = 3'd5
    } dump_state_t;

    localparam logic [15:0] RF_TAG = 16'h8000;

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_dump_reader.sv
// Streams the register file (when MEM_DUMP_RF_EN is defined) and then all of data memory
// out over a valid/ready port, one tagged word at a time, ascending addresses.
module mem_dump_reader
    import mips_dump_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DMEM_AW = 8,
    parameter int RF_AW   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [RF_AW-1:0]   rf_rd_addr,
    input  logic [DATA_W-1:0]  rf_rd_data,
    output logic               dmem_rd_en,
    output logic [DMEM_AW-1:0] dmem_rd_addr,
    input  logic [DATA_W-1:0]  dmem_rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [15:0]        out_tag,
    output logic               out_last
);

    localparam int CW         = max_w(RF_AW, DMEM_AW);
    localparam int DMEM_DEPTH = 2 ** DMEM_AW;
    localparam logic [CW-1:0] DM_LAST = CW'(DMEM_DEPTH - 1);

    dump_state_t   state;
    logic [CW-1:0] cnt;

`ifdef MEM_DUMP_RF_EN
    localparam int RF_DEPTH = 2 ** RF_AW;
    localparam logic [CW-1:0] RF_LAST = CW'(RF_DEPTH - 1);

    logic is_rf;

    assign rf_rd_addr = (state == RF_RD) ? cnt[RF_AW-1:0] : '0;
`else
    logic rf_data_unused;

    assign rf_rd_addr     = '0;
    assign rf_data_unused = ^rf_rd_data;
`endif

    assign dmem_rd_addr = cnt[DMEM_AW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dmem_rd_en <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_tag    <= '0;
            out_last   <= 1'b0;
`ifdef MEM_DUMP_RF_EN
            is_rf      <= 1'b0;
`endif
        end else begin
            done       <= 1'b0;
            dmem_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt  <= '0;
                        busy <= 1'b1;
`ifdef MEM_DUMP_RF_EN
                        is_rf <= 1'b1;
                        state <= RF_RD;
`else
                        dmem_rd_en <= 1'b1;
                        state      <= DM_REQ;
`endif
                    end
                end
                RF_RD: begin
                    // The register file always precedes memory, so an RF word is never last.
                    out_data  <= rf_rd_data;
                    out_tag   <= RF_TAG | {1'b0, 15'(cnt)};
                    out_last  <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= EMIT;
                end
                DM_REQ: state <= DM_WAIT;
                DM_WAIT: begin
                    out_data  <= dmem_rd_data;
                    out_tag   <= {1'b0, 15'(cnt)};
                    out_last  <= (cnt == DM_LAST);
                    out_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
`ifdef MEM_DUMP_RF_EN
                        if (is_rf) begin
                            if (cnt == RF_LAST) begin
                                cnt        <= '0;
                                is_rf      <= 1'b0;
                                dmem_rd_en <= 1'b1;
                                state      <= DM_REQ;
                            end else begin
                                cnt   <= cnt + 1'b1;
                                state <= RF_RD;
                            end
                        end else
`endif
                        if (cnt == DM_LAST) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            cnt        <= cnt + 1'b1;
                            dmem_rd_en <= 1'b1;
                            state      <= DM_REQ;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Randomized self-checking bench for mem_dump_reader; expected streams come from the source arrays.
module tb_mem_dump_reader;

`ifdef MEM_DUMP_RF_EN
    localparam int NRF = 32;
`else
    localparam int NRF = 0;
`endif
    localparam int NDM = 256;
    localparam int NW  = NRF + NDM;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, dmem_rd_en, out_valid, out_last;
    logic        out_ready = 1'b0;
    logic [4:0]  rf_rd_addr;
    logic [7:0]  dmem_rd_addr;
    logic [31:0] rf_rd_data, dmem_rd_data, out_data;
    logic [15:0] out_tag;

    logic [31:0] rf   [32];
    logic [31:0] dmem [256];

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_data [$];
    logic [15:0] exp_tag  [$];
    logic [31:0] got_data [$];
    logic [15:0] got_tag  [$];
    logic        got_last [$];
    logic [7:0]  rd_addr  [$];
    int rd_cnt, unstable, busy_cyc, done_cnt, done_cyc, last_hs_cyc, rf_nz;
    bit timed_out, rst_hit, rst_valid, rst_busy, done_after, busy_after;

    mem_dump_reader #(.DATA_W(32), .DMEM_AW(8), .RF_AW(5)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .dmem_rd_en(dmem_rd_en), .dmem_rd_addr(dmem_rd_addr), .dmem_rd_data(dmem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_last(out_last)
    );

    always #5 clk = ~clk;

    assign rf_rd_data = rf[rf_rd_addr];
    always @(posedge clk) if (dmem_rd_en) dmem_rd_data <= dmem[dmem_rd_addr];

    task automatic load_fixed();
        for (int i = 0; i < 32; i++) rf[i] = 32'(i);
        for (int i = 0; i < 256; i++) dmem[i] = 32'h1000 + 32'(i);
    endtask

    task automatic load_random();
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        for (int i = 0; i < 256; i++) dmem[i] = $urandom;
    endtask

    task automatic build_exp();
        exp_data.delete(); exp_tag.delete();
        for (int i = 0; i < NRF; i++) begin
            exp_data.push_back(rf[i]); exp_tag.push_back(16'h8000 + 16'(i));
        end
        for (int i = 0; i < NDM; i++) begin
            exp_data.push_back(dmem[i]); exp_tag.push_back(16'(i));
        end
    endtask

    // mode: 0 ready always high, 1 toggling, 2 random. Collects observations only.
    task automatic run_dump(input int mode, input int rst_word, input int start_word, input bit fin_start);
        bit stalled = 0, start_used = 0, finished = 0;
        logic [31:0] hd = '0; logic [15:0] ht = '0; logic hl = 0;
        got_data.delete(); got_tag.delete(); got_last.delete(); rd_addr.delete();
        rd_cnt = 0; unstable = 0; busy_cyc = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
        rf_nz = 0; timed_out = 0; rst_hit = 0; rst_valid = 0; rst_busy = 0;
        done_after = 0; busy_after = 0;
        @(posedge clk); #1; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (dmem_rd_en) begin rd_cnt++; rd_addr.push_back(dmem_rd_addr); end
            if (rf_rd_addr != 0) rf_nz++;
            if (stalled && !(out_valid === 1'b1 && out_data === hd && out_tag === ht && out_last === hl))
                unstable++;
            stalled = out_valid && !out_ready;
            hd = out_data; ht = out_tag; hl = out_last;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (out_valid && out_ready) begin
                got_data.push_back(out_data); got_tag.push_back(out_tag); got_last.push_back(out_last);
                last_hs_cyc = cyc;
            end
            if (done) begin finished = 1; break; end
            @(posedge clk); #1;
            if (rst_word >= 0 && got_data.size() == rst_word) begin
                reset = 1'b1; #1;
                rst_valid = out_valid; rst_busy = busy; rst_hit = 1;
                @(posedge clk); #1; reset = 1'b0;
                finished = 1;
                break;
            end
            start = (start_word >= 0 && got_data.size() == start_word && !start_used);
            if (start) start_used = 1;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
        if (!finished) timed_out = 1;
        if (!rst_hit && finished) begin
            if (fin_start) start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk);
            done_after = done; busy_after = busy;
            repeat (3) @(negedge clk);
            busy_after = busy_after | busy;
        end
    endtask

    task automatic check_stream(input string name);
        int mism = 0, first = -1;
        checks++;
        if (timed_out) begin
            errors++; $display("FAIL %s_timeout: dump did not finish within cycle budget", name);
        end
        checks++;
        if (got_data.size() !== NW) begin
            errors++; $display("FAIL %s_count: got %0d words, expected %0d", name, got_data.size(), NW);
        end
        for (int i = 0; i < got_data.size() && i < NW; i++)
            if (got_data[i] !== exp_data[i] || got_tag[i] !== exp_tag[i] || got_last[i] !== (i == NW - 1)) begin
                mism++; if (first < 0) first = i;
            end
        checks++;
        if (mism !== 0) begin
            errors++;
            $display("FAIL %s_seq: %0d bad words, first at %0d: data %h tag %h last %b, expected data %h tag %h last %b",
                     name, mism, first, got_data[first], got_tag[first], got_last[first],
                     exp_data[first], exp_tag[first], first == NW - 1);
        end
        checks++;
        if (unstable !== 0) begin
            errors++; $display("FAIL %s_stable: %0d cycles with outputs changed while stalled, expected 0", name, unstable);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL %s_done: done seen %0d cycles, expected 1", name, done_cnt);
        end
        checks++;
        if (rd_cnt !== NDM) begin
            errors++; $display("FAIL %s_rd_en: dmem_rd_en high %0d cycles, expected %0d", name, rd_cnt, NDM);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: %b expected 0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: %b expected 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last: %b expected 0", out_last); end
        checks++; if (dmem_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: %b expected 0", dmem_rd_en); end
        checks++; if (out_data !== 32'h0 || out_tag !== 16'h0) begin
            errors++; $display("FAIL rst_out: data %h tag %h expected 0", out_data, out_tag); end
        checks++; if (rf_rd_addr !== 5'h0 || dmem_rd_addr !== 8'h0) begin
            errors++; $display("FAIL rst_addr: rf %h dmem %h expected 0", rf_rd_addr, dmem_rd_addr); end
        @(posedge clk); #1; reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy: %b expected 0 without start", busy); end
    endtask

    task automatic test_full_dump();
        int bad = 0;
        load_fixed(); build_exp();
        run_dump(0, -1, -1, 0);
        check_stream("full");
        checks++;
        if (done_cyc !== last_hs_cyc + 1) begin
            errors++; $display("FAIL full_done_time: done at %0d, final handshake at %0d", done_cyc, last_hs_cyc);
        end
        checks++;
        if (busy_cyc !== 2 * NRF + 3 * NDM + 1) begin
            errors++; $display("FAIL full_latency: busy %0d cycles, expected %0d", busy_cyc, 2 * NRF + 3 * NDM + 1);
        end
        for (int i = 0; i < rd_addr.size(); i++) if (rd_addr[i] !== 8'(i)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL full_rd_addr: %0d strobes at wrong address, expected ascending 0..255", bad);
        end
        checks++;
        if (done_after !== 1'b0 || busy_after !== 1'b0) begin
            errors++; $display("FAIL full_idle: done %b busy %b after dump, expected 0 0", done_after, busy_after);
        end
`ifndef MEM_DUMP_RF_EN
        checks++;
        if (rf_nz !== 0) begin
            errors++; $display("FAIL no_rf_addr: rf_rd_addr nonzero %0d cycles, expected 0", rf_nz);
        end
        checks++;
        if (got_tag.size() == 0 || got_tag[0] !== 16'h0000) begin
            errors++; $display("FAIL no_rf_first_tag: %h expected 0000", got_tag.size() ? got_tag[0] : 16'hxxxx);
        end
`endif
    endtask

    task automatic test_backpressure();
        load_random(); build_exp();
        run_dump(1, -1, -1, 0);
        check_stream("toggle");
    endtask

    task automatic test_random_ready();
        load_random(); build_exp();
        run_dump(2, -1, -1, 0);
        check_stream("rand");
    endtask

    task automatic test_reset_mid();
        load_random(); build_exp();
        run_dump(0, 40, -1, 0);
        checks++;
        if (rst_hit !== 1'b1 || rst_valid !== 1'b0 || rst_busy !== 1'b0) begin
            errors++; $display("FAIL midrst_state: hit %b valid %b busy %b, expected 1 0 0", rst_hit, rst_valid, rst_busy);
        end
        checks++;
        if (got_data.size() !== 40) begin
            errors++; $display("FAIL midrst_words: %0d words before reset, expected 40", got_data.size());
        end
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_no_resume: busy %b valid %b, expected 0 0", busy, out_valid);
        end
        run_dump(2, -1, -1, 0);
        checks++;
        if (got_tag.size() == 0 || got_tag[0] !== exp_tag[0]) begin
            errors++; $display("FAIL midrst_restart_tag: %h expected %h", got_tag.size() ? got_tag[0] : 16'hxxxx, exp_tag[0]);
        end
        check_stream("midrst");
    endtask

    task automatic test_start_busy();
        load_random(); build_exp();
        run_dump(2, -1, 10, 1);
        check_stream("busy_start");
        checks++;
        if (busy_after !== 1'b0) begin
            errors++; $display("FAIL fin_start: busy %b after start in final cycle, expected 0", busy_after);
        end
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_backpressure();
        test_random_ready();
        test_reset_mid();
        test_start_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
